// File: rtl/pingpong_ctrl.sv
// Two-digit BCD ping-pong counter: steps up to a BCD bound and back down to zero,
// paced by a prescaler, with pause, direction flip and 7-segment digit outputs.
module pingpong_ctrl #(
    parameter int unsigned TICK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       flip,
    input  logic [7:0] max_bcd,
    output logic [3:0] d1,
    output logic [3:0] d0,
    output logic [3:0] u1,
    output logic [3:0] u0,
    output logic       step
);
    typedef enum logic [1:0] {
        PAUSE = 2'd0,
        UP    = 2'd1,
        DOWN  = 2'd2
    } state_t;

    localparam logic [25:0] TICK_LAST = 26'(TICK_DIV - 1);

    state_t      state_r;
    state_t      stateNext_s;
    logic        dirUp_r;
    logic [25:0] presc_r;
    logic [3:0]  tens_r;
    logic [3:0]  ones_r;
    logic        tick_s;
    logic        dirFlip_s;
    logic        dirNext_s;
    logic [7:0]  maxEff_s;
    logic [7:0]  count_s;
    logic [7:0]  countNext_s;

    function automatic logic [7:0] bcdInc(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end else begin
            return {v[7:4], v[3:0] + 4'd1};
        end
    endfunction

    function automatic logic [7:0] bcdDec(input logic [7:0] v);
        if (v[3:0] == 4'd0) begin
            return {v[7:4] - 4'd1, 4'd9};
        end else begin
            return {v[7:4], v[3:0] - 4'd1};
        end
    endfunction

    // Step decision: flip applies first, then the tick is judged in the new direction.
    // Valid BCD values order the same as plain binary, so comparisons use the raw bytes.
    always_comb begin
        tick_s      = enable && (state_r != PAUSE) && (presc_r == TICK_LAST);
        maxEff_s    = ((max_bcd[7:4] > 4'd9) || (max_bcd[3:0] > 4'd9)) ? 8'h99 : max_bcd;
        count_s     = {tens_r, ones_r};
        dirFlip_s   = flip ? ~dirUp_r : dirUp_r;
        dirNext_s   = dirFlip_s;
        countNext_s = count_s;
        if (tick_s) begin
            if (dirFlip_s) begin
                if (count_s < maxEff_s) begin
                    countNext_s = bcdInc(count_s);
                end else begin
                    dirNext_s = 1'b0;
                    if (count_s != 8'h00) begin
                        countNext_s = bcdDec(count_s);
                    end else begin
                        countNext_s = count_s;
                    end
                end
            end else begin
                if (count_s != 8'h00) begin
                    countNext_s = bcdDec(count_s);
                end else begin
                    dirNext_s = 1'b1;
                    if (maxEff_s != 8'h00) begin
                        countNext_s = 8'h01;
                    end else begin
                        countNext_s = count_s;
                    end
                end
            end
        end else begin
            countNext_s = count_s;
        end
        if (!enable) begin
            stateNext_s = PAUSE;
        end else if (dirNext_s) begin
            stateNext_s = UP;
        end else begin
            stateNext_s = DOWN;
        end
    end

    // State, prescaler, count and registered display outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= PAUSE;
            dirUp_r <= 1'b1;
            presc_r <= 26'd0;
            tens_r  <= 4'd0;
            ones_r  <= 4'd0;
            step    <= 1'b0;
            u0      <= 4'd1;
            u1      <= 4'd0;
        end else begin
            state_r <= stateNext_s;
            dirUp_r <= dirNext_s;
            presc_r <= (enable && !tick_s) ? presc_r + 26'd1 : 26'd0;
            tens_r  <= countNext_s[7:4];
            ones_r  <= countNext_s[3:0];
            step    <= tick_s;
            u0      <= dirNext_s ? 4'd1 : 4'd0;
            u1      <= (stateNext_s != PAUSE) ? 4'd15 : 4'd0;
        end
    end

    assign d1 = tens_r;
    assign d0 = ones_r;

endmodule

// File: tb/tb_pingpong_ctrl.sv
// Bench for pingpong_ctrl with TICK_DIV=4: directed vector table, then a
// randomized run checked against an integer reference model through a queue.
module tb_pingpong_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       flip = 1'b0;
    logic [7:0] max_bcd = 8'h00;
    logic [3:0] d1, d0, u1, u0;
    logic       step;

    pingpong_ctrl #(.TICK_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .flip(flip), .max_bcd(max_bcd),
        .d1(d1), .d0(d0), .u1(u1), .u0(u0), .step(step)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rstN;
        logic       en;
        logic       fl;
        logic [7:0] mx;
        int         n;
        logic [3:0] d1;
        logic [3:0] d0;
        logic [3:0] u0;
        logic [3:0] u1;
        logic       st;
    } vec_t;

    typedef struct {
        logic [3:0] d1;
        logic [3:0] d0;
        logic [3:0] u0;
        logic [3:0] u1;
        logic       st;
    } exp_t;

    vec_t tbl[$];
    exp_t sbq[$];
    int   nVec = 0;
    int   nErr = 0;

    int mCount, mPresc;
    bit mUp, mRun, mStep;

    function automatic void add(input logic rs, input logic e, input logic f, input logic [7:0] m,
                                input int n, input logic [3:0] a1, input logic [3:0] a0,
                                input logic [3:0] x0, input logic [3:0] x1, input logic s);
        vec_t v;
        v.rstN = rs; v.en = e; v.fl = f; v.mx = m; v.n = n;
        v.d1 = a1; v.d0 = a0; v.u0 = x0; v.u1 = x1; v.st = s;
        tbl.push_back(v);
    endfunction

    task automatic pushExp(input logic [3:0] a1, input logic [3:0] a0, input logic [3:0] x0,
                           input logic [3:0] x1, input logic s);
        exp_t e;
        e.d1 = a1; e.d0 = a0; e.u0 = x0; e.u1 = x1; e.st = s;
        sbq.push_back(e);
    endtask

    task automatic checkOut(input string name, input int idx);
        exp_t e;
        nVec++;
        if (sbq.size() == 0) begin
            nErr++;
            $display("FAIL %s #%0d: scoreboard empty", name, idx);
        end else begin
            e = sbq.pop_front();
            if (d1 !== e.d1 || d0 !== e.d0 || u0 !== e.u0 || u1 !== e.u1 || step !== e.st) begin
                nErr++;
                $display("FAIL %s #%0d: got d1=%0d d0=%0d u0=%0d u1=%0d step=%0d, want d1=%0d d0=%0d u0=%0d u1=%0d step=%0d",
                         name, idx, d1, d0, u0, u1, step, e.d1, e.d0, e.u0, e.u1, e.st);
            end
        end
    endtask

    // Reference behaviour for one rising edge, in plain integers.
    task automatic modelEdge(input logic rs, input logic e, input logic f, input logic [7:0] m);
        int  maxv;
        bit  tick;
        if (!rs) begin
            mCount = 0; mUp = 1; mPresc = 0; mRun = 0; mStep = 0;
        end else begin
            tick   = e && (mPresc == 3);
            mPresc = (e && mPresc != 3) ? mPresc + 1 : 0;
            if (f) mUp = !mUp;
            mStep = tick;
            if (tick) begin
                maxv = (m[7:4] > 4'd9 || m[3:0] > 4'd9) ? 99 : int'(m[7:4]) * 10 + int'(m[3:0]);
                if (mUp) begin
                    if (mCount < maxv) mCount = mCount + 1;
                    else begin
                        mUp = 0;
                        if (mCount > 0) mCount = mCount - 1;
                    end
                end else begin
                    if (mCount > 0) mCount = mCount - 1;
                    else begin
                        mUp = 1;
                        if (maxv > 0) mCount = 1;
                    end
                end
            end
            mRun = e;
        end
    endtask

    initial begin
        logic       rN, e, f;
        logic [7:0] m;

        // rst en fl max n | d1 d0 u0 u1 step
        add(0, 0, 0, 8'h03, 1, 4'd0, 4'd0, 4'd1, 4'd0,  1'b0);
        add(1, 1, 0, 8'h03, 1, 4'd0, 4'd0, 4'd1, 4'd15, 1'b0);
        add(1, 1, 0, 8'h03, 2, 4'd0, 4'd0, 4'd1, 4'd15, 1'b0);
        add(1, 1, 0, 8'h03, 1, 4'd0, 4'd1, 4'd1, 4'd15, 1'b1);
        add(1, 1, 0, 8'h03, 1, 4'd0, 4'd1, 4'd1, 4'd15, 1'b0);
        add(1, 1, 0, 8'h03, 3, 4'd0, 4'd2, 4'd1, 4'd15, 1'b1);
        add(1, 1, 0, 8'h03, 4, 4'd0, 4'd3, 4'd1, 4'd15, 1'b1);
        add(1, 1, 0, 8'h03, 4, 4'd0, 4'd2, 4'd0, 4'd15, 1'b1);
        add(1, 1, 0, 8'h03, 4, 4'd0, 4'd1, 4'd0, 4'd15, 1'b1);
        add(1, 1, 0, 8'h03, 4, 4'd0, 4'd0, 4'd0, 4'd15, 1'b1);
        add(1, 1, 0, 8'h03, 4, 4'd0, 4'd1, 4'd1, 4'd15, 1'b1);
        add(1, 1, 0, 8'h12, 32, 4'd0, 4'd9, 4'd1, 4'd15, 1'b1);
        add(1, 1, 0, 8'h12, 4, 4'd1, 4'd0, 4'd1, 4'd15, 1'b1);
        add(1, 1, 0, 8'h12, 4, 4'd1, 4'd1, 4'd1, 4'd15, 1'b1);
        add(1, 1, 0, 8'h12, 4, 4'd1, 4'd2, 4'd1, 4'd15, 1'b1);
        add(1, 1, 0, 8'h12, 4, 4'd1, 4'd1, 4'd0, 4'd15, 1'b1);
        add(1, 1, 0, 8'h12, 4, 4'd1, 4'd0, 4'd0, 4'd15, 1'b1);
        add(1, 1, 0, 8'h12, 4, 4'd0, 4'd9, 4'd0, 4'd15, 1'b1);
        add(1, 1, 0, 8'h12, 16, 4'd0, 4'd5, 4'd0, 4'd15, 1'b1);
        add(1, 1, 1, 8'h12, 1, 4'd0, 4'd5, 4'd1, 4'd15, 1'b0);
        add(1, 1, 0, 8'h12, 2, 4'd0, 4'd5, 4'd1, 4'd15, 1'b0);
        add(1, 1, 1, 8'h12, 1, 4'd0, 4'd4, 4'd0, 4'd15, 1'b1);
        add(1, 1, 1, 8'h12, 1, 4'd0, 4'd4, 4'd1, 4'd15, 1'b0);
        add(1, 1, 0, 8'h12, 3, 4'd0, 4'd5, 4'd1, 4'd15, 1'b1);
        add(1, 1, 0, 8'h12, 4, 4'd0, 4'd6, 4'd1, 4'd15, 1'b1);
        add(1, 1, 0, 8'h12, 4, 4'd0, 4'd7, 4'd1, 4'd15, 1'b1);
        add(1, 1, 0, 8'h04, 4, 4'd0, 4'd6, 4'd0, 4'd15, 1'b1);
        add(1, 1, 1, 8'hA5, 1, 4'd0, 4'd6, 4'd1, 4'd15, 1'b0);
        add(1, 1, 0, 8'hA5, 3, 4'd0, 4'd7, 4'd1, 4'd15, 1'b1);
        add(1, 1, 0, 8'hA5, 2, 4'd0, 4'd7, 4'd1, 4'd15, 1'b0);
        add(1, 0, 0, 8'hA5, 1, 4'd0, 4'd7, 4'd1, 4'd0,  1'b0);
        add(1, 0, 0, 8'hA5, 5, 4'd0, 4'd7, 4'd1, 4'd0,  1'b0);
        add(1, 1, 0, 8'hA5, 3, 4'd0, 4'd7, 4'd1, 4'd15, 1'b0);
        add(1, 1, 0, 8'hA5, 1, 4'd0, 4'd8, 4'd1, 4'd15, 1'b1);
        add(1, 0, 1, 8'hA5, 1, 4'd0, 4'd8, 4'd0, 4'd0,  1'b0);
        add(1, 1, 0, 8'hA5, 4, 4'd0, 4'd7, 4'd0, 4'd15, 1'b1);
        add(1, 1, 0, 8'hA5, 3, 4'd0, 4'd7, 4'd0, 4'd15, 1'b0);
        add(0, 1, 0, 8'hA5, 1, 4'd0, 4'd0, 4'd1, 4'd0,  1'b0);
        add(1, 1, 0, 8'hA5, 4, 4'd0, 4'd1, 4'd1, 4'd15, 1'b1);
        add(1, 1, 0, 8'h00, 4, 4'd0, 4'd0, 4'd0, 4'd15, 1'b1);
        add(1, 1, 0, 8'h00, 4, 4'd0, 4'd0, 4'd1, 4'd15, 1'b1);
        add(1, 1, 0, 8'h00, 4, 4'd0, 4'd0, 4'd0, 4'd15, 1'b1);

        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                @(negedge clk);
                rst_n   = tbl[i].rstN;
                enable  = tbl[i].en;
                flip    = (k == 0) ? tbl[i].fl : 1'b0;
                max_bcd = tbl[i].mx;
                if (k == tbl[i].n - 1)
                    pushExp(tbl[i].d1, tbl[i].d0, tbl[i].u0, tbl[i].u1, tbl[i].st);
                @(posedge clk);
                #1;
                if (k == tbl[i].n - 1) checkOut("table", i);
            end
        end

        // Randomized run against the model; cycle 0 resets both.
        m = 8'h25;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            rN = (c == 0) ? 1'b0 : ($urandom_range(0, 149) != 0);
            e  = ($urandom_range(0, 9) != 0);
            f  = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 3))
                    0: m = 8'h00;
                    1: m = 8'(($urandom_range(10, 15) << 4) | $urandom_range(0, 15));
                    2: m = {4'd0, 4'($urandom_range(1, 9))};
                    default: m = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9))};
                endcase
            end
            rst_n = rN; enable = e; flip = f; max_bcd = m;
            modelEdge(rN, e, f, m);
            pushExp(4'(mCount / 10), 4'(mCount % 10), mUp ? 4'd1 : 4'd0, mRun ? 4'd15 : 4'd0, mStep);
            @(posedge clk);
            #1;
            checkOut("random", c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule

// File: doc/pingpong_ctrl.md
PINGPONG_CTRL -- requirements
Module: pingpong_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 25000000, meaning clock cycles per count step (legal range 2..2^26-1).
REQ-002 The block SHALL have port clk, input, 1, meaning the single system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, meaning synchronous active-low reset.
REQ-004 The block SHALL have port enable, input, 1, meaning run when high, pause when low.
REQ-005 The block SHALL have port flip, input, 1, meaning single-cycle pulse that reverses count direction.
REQ-006 The block SHALL have port max_bcd, input, 8, meaning upper bound as BCD: [7:4] tens, [3:0] ones.
REQ-007 The block SHALL have ports d1 and d0, output, 4 each, meaning tens and ones BCD digits of the count, driving the 7-segment decoder.
REQ-008 The block SHALL have ports u1 and u0, output, 4 each, meaning status digits driving the 7-segment decoder.
REQ-009 The block SHALL have port step, output, 1, meaning one-cycle pulse in the cycle a count step is applied.

Function
REQ-010 The block SHALL implement FSM states PAUSE, UP and DOWN, with a direction bit retained while in PAUSE.
REQ-011 The block SHALL implement a prescaler that counts 0..TICK_DIV-1 while enable=1 and asserts an internal tick when it equals TICK_DIV-1, then wraps to 0.
REQ-012 The prescaler SHALL be held at 0 while enable=0; the first tick after resume is TICK_DIV cycles after enable rises.
REQ-013 The block SHALL treat max_bcd as 99 if either nibble is greater than 9, and SHALL sample it continuously (no latching).
REQ-014 The count SHALL be a 2-digit BCD value 0..99; each step changes it by exactly 1, with a ones-digit carry or borrow into tens (09->10, 10->09).
REQ-015 On a tick in UP: if count < max, the count SHALL increment; if count >= max, the state SHALL become DOWN and the count SHALL decrement in the same cycle; if count = 0 and max = 0, the count SHALL hold and the state SHALL become DOWN.
REQ-016 On a tick in DOWN: if count > 0, the count SHALL decrement; if count = 0, the state SHALL become UP and the count SHALL become 1, unless max = 0, in which case the count SHALL stay 0.
REQ-017 When the count exceeds max because max was lowered, the next tick SHALL force DOWN and a decrement, whatever the current direction.
REQ-018 A flip pulse SHALL toggle direction immediately (UP<->DOWN, or the stored direction in PAUSE) without changing the count.
REQ-019 When flip and tick occur in the same cycle, the flip SHALL be applied first, and the step SHALL then be evaluated in the new direction using REQ-015/016.
REQ-020 When enable=0, the block SHALL enter PAUSE on the next edge and hold the count; when enable=1, it SHALL leave PAUSE to the stored direction on the next edge.
REQ-021 step SHALL pulse high for exactly one cycle, coincident with the count register update on each tick; step SHALL be 0 in PAUSE.
REQ-022 Outputs SHALL be registered: d1/d0 = count digits; u0 = 4'd1 when direction is up, else 4'd0; u1 = 4'd15 (blank) when running, else 4'd0 (PAUSE indicator).
REQ-023 Every output SHALL remain BCD 0..9, except u1 = 15, so that the decoder's blank code is used only for u1.

Reset
REQ-024 With rst_n = 0 at a rising edge, the block SHALL set the count to 00, the state to PAUSE with direction up, and the prescaler to 0.
REQ-025 The reset output values SHALL be d1=0, d0=0, u0=1, u1=0 and step=0.
REQ-026 Reset SHALL override enable, flip and tick in the same cycle and SHALL abort any step in progress.

Verification (TICK_DIV=4)
REQ-027 Stimulus: reset, then enable=1, max_bcd=8'h03 -> required: step every 4 cycles and count sequence 01,02,03,02,01,00,01; u0 goes 1->0 on the 03->02 step.
REQ-028 Stimulus: max_bcd=8'h12, count=09 UP, tick -> required: count 10 (carry); then, from DOWN, 10 -> 09 (borrow).
REQ-029 Stimulus: count=05 UP, flip in the same cycle as a tick -> required: count 04, u0=0; flip in a non-tick cycle -> required: count unchanged and direction toggled.
REQ-030 Stimulus: count=07 UP, max_bcd changed to 8'h04 -> required: next step gives 06 with direction DOWN; stimulus max_bcd=8'hA5 -> required: treated as 99.
REQ-031 Stimulus: enable dropped mid-count -> required: u1=0, count frozen, no step; re-enable -> required: first step after exactly 4 cycles in the stored direction.
REQ-032 Stimulus: rst_n low for 1 cycle while a tick is due -> required: outputs 0,0,u0=1,u1=0 and step=0 that cycle.
